// File: rtl/decoder_strobe.sv
// Registered binary-to-one-hot strobe decoder with valid/ready handshake and timed idle gap.
// Optional macro DECODER_STROBE_ERR_EN: out-of-range requests are dropped and flagged on a sticky ERR.
module decoder_strobe #(
  parameter int N    = 2,
  parameter int OUTS = 4,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    I,
  input  logic            VALID,
  output logic            READY,
  output logic [OUTS-1:0] O,
  output logic            BUSY,
  output logic            ERR
);

  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [N:0]    OUTS_LIM = (N + 1)'(OUTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OUTS-1:0] o_q, o_d;
  logic [OUTS-1:0] hot;
  logic            take;

  assign READY = (state_q == ST_IDLE) && !RESET;
  assign BUSY  = (state_q != ST_IDLE);
  assign O     = o_q;
  assign take  = VALID && READY;

  // An index at or above OUTS matches no line, so the decode is naturally all zero.
  always_comb begin
    hot = '0;
    for (int k = 0; k < OUTS; k++) begin
      if ({1'b0, I} == (N + 1)'(k)) begin
        hot[k] = 1'b1;
      end
    end
  end

`ifdef DECODER_STROBE_ERR_EN
  logic out_of_range;
  logic err_q, err_d;

  assign out_of_range = ({1'b0, I} >= OUTS_LIM);
  assign err_d        = err_q || (take && out_of_range);
  assign ERR          = err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
`ifdef DECODER_STROBE_ERR_EN
          if (!out_of_range) begin
            state_d = ST_STROBE;
            cnt_d   = HOLD_LD;
            o_d     = hot;
          end
`else
          state_d = ST_STROBE;
          cnt_d   = HOLD_LD;
          o_d     = hot;
`endif
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          o_d = '0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        o_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed bench for decoder_strobe: default, HOLD=1/GAP=0 and OUTS=3 instances.
// ERR expectations follow DECODER_STROBE_ERR_EN when the bench is built with it.
module tb_decoder_strobe;

  logic clk;

  logic       d_rst, d_valid, d_ready, d_busy, d_err;
  logic [1:0] d_i;
  logic [3:0] d_o;

  logic       f_rst, f_valid, f_ready, f_busy, f_err;
  logic [1:0] f_i;
  logic [3:0] f_o;

  logic       s_rst, s_valid, s_ready, s_busy, s_err;
  logic [1:0] s_i;
  logic [2:0] s_o;

  int vec_count;
  int miss_count;

  decoder_strobe #(.N(2), .OUTS(4), .HOLD(4), .GAP(1)) dut_def (
    .CLK(clk), .RESET(d_rst), .I(d_i), .VALID(d_valid),
    .READY(d_ready), .O(d_o), .BUSY(d_busy), .ERR(d_err)
  );

  decoder_strobe #(.N(2), .OUTS(4), .HOLD(1), .GAP(0)) dut_fast (
    .CLK(clk), .RESET(f_rst), .I(f_i), .VALID(f_valid),
    .READY(f_ready), .O(f_o), .BUSY(f_busy), .ERR(f_err)
  );

  decoder_strobe #(.N(2), .OUTS(3), .HOLD(4), .GAP(1)) dut_small (
    .CLK(clk), .RESET(s_rst), .I(s_i), .VALID(s_valid),
    .READY(s_ready), .O(s_o), .BUSY(s_busy), .ERR(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] idx);
    d_valid = valid;
    d_i     = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_o;
    logic       exp_ready;
    int         pos;

    vec_count  = 0;
    miss_count = 0;
    d_rst = 1'b1; f_rst = 1'b1; s_rst = 1'b1;
    applyStimulus(1'b0, 2'd0);
    f_valid = 1'b0; f_i = 2'd0;
    s_valid = 1'b0; s_i = 2'd0;

    tick();
    tick();
    checkOutput("rst_o", 32'(d_o), 32'h0);
    checkOutput("rst_busy", 32'(d_busy), 32'h0);
    checkOutput("rst_ready", 32'(d_ready), 32'h0);
    checkOutput("rst_err", 32'(s_err), 32'h0);

    d_rst = 1'b0; f_rst = 1'b0; s_rst = 1'b0;
    #1;
    checkOutput("idle_ready", 32'(d_ready), 32'h1);
    checkOutput("fast_idle_ready", 32'(f_ready), 32'h1);

    $display("[TB] single request I=2");
    applyStimulus(1'b1, 2'd2);
    tick();
    applyStimulus(1'b0, 2'd2);
    for (int c = 1; c <= 6; c++) begin
      exp_o     = (c <= 4) ? 4'b0100 : 4'b0000;
      exp_ready = (c == 6);
      checkOutput($sformatf("single_o_c%0d", c), 32'(d_o), 32'(exp_o));
      checkOutput($sformatf("single_ready_c%0d", c), 32'(d_ready), 32'(exp_ready));
      checkOutput($sformatf("single_busy_c%0d", c), 32'(d_busy), 32'(c <= 5));
      if (c < 6) tick();
    end

    $display("[TB] VALID held with I=3");
    applyStimulus(1'b1, 2'd3);
    for (int p = 0; p < 12; p++) begin
      tick();
      pos       = (p % 6) + 1;
      exp_o     = (pos <= 4) ? 4'b1000 : 4'b0000;
      exp_ready = (pos == 6);
      checkOutput($sformatf("held_o_p%0d", p), 32'(d_o), 32'(exp_o));
      checkOutput($sformatf("held_ready_p%0d", p), 32'(d_ready), 32'(exp_ready));
    end
    applyStimulus(1'b0, 2'd3);

    $display("[TB] index changes while busy");
    applyStimulus(1'b1, 2'd2);
    tick();
    checkOutput("chg_o_c1", 32'(d_o), 32'h4);
    applyStimulus(1'b1, 2'd1);
    tick();
    checkOutput("chg_o_c2", 32'(d_o), 32'h4);
    checkOutput("chg_onehot_c2", 32'($countones(d_o) <= 1), 32'h1);
    applyStimulus(1'b1, 2'd3);
    tick();
    checkOutput("chg_o_c3", 32'(d_o), 32'h4);
    applyStimulus(1'b1, 2'd0);
    tick();
    checkOutput("chg_o_c4", 32'(d_o), 32'h4);
    applyStimulus(1'b0, 2'd0);
    tick();
    checkOutput("chg_o_c5", 32'(d_o), 32'h0);
    checkOutput("chg_busy_c5", 32'(d_busy), 32'h1);
    tick();
    checkOutput("chg_ready_c6", 32'(d_ready), 32'h1);

    $display("[TB] reset during strobe");
    applyStimulus(1'b1, 2'd1);
    tick();
    applyStimulus(1'b0, 2'd1);
    checkOutput("abort_o_c1", 32'(d_o), 32'h2);
    tick();
    checkOutput("abort_o_c2", 32'(d_o), 32'h2);
    d_rst = 1'b1;
    tick();
    checkOutput("abort_o", 32'(d_o), 32'h0);
    checkOutput("abort_busy", 32'(d_busy), 32'h0);
    checkOutput("abort_ready_in_rst", 32'(d_ready), 32'h0);
    d_rst = 1'b0;
    #1;
    checkOutput("abort_ready_after", 32'(d_ready), 32'h1);
    applyStimulus(1'b1, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0);
    checkOutput("abort_new_o", 32'(d_o), 32'h1);
    for (int c = 2; c <= 6; c++) tick();
    checkOutput("abort_new_ready", 32'(d_ready), 32'h1);

    $display("[TB] HOLD=1 GAP=0 back to back");
    f_valid = 1'b1; f_i = 2'd0;
    tick();
    checkOutput("fast_o_c1", 32'(f_o), 32'h1);
    checkOutput("fast_ready_c1", 32'(f_ready), 32'h0);
    f_i = 2'd1;
    tick();
    checkOutput("fast_o_c2", 32'(f_o), 32'h0);
    checkOutput("fast_ready_c2", 32'(f_ready), 32'h1);
    tick();
    f_valid = 1'b0;
    checkOutput("fast_o_c3", 32'(f_o), 32'h2);
    tick();
    checkOutput("fast_o_c4", 32'(f_o), 32'h0);
    checkOutput("fast_ready_c4", 32'(f_ready), 32'h1);

    $display("[TB] OUTS=3 with out-of-range I=3");
    s_valid = 1'b1; s_i = 2'd3;
    tick();
    s_valid = 1'b0;
`ifdef DECODER_STROBE_ERR_EN
    checkOutput("oor_o", 32'(s_o), 32'h0);
    checkOutput("oor_ready", 32'(s_ready), 32'h1);
    checkOutput("oor_busy", 32'(s_busy), 32'h0);
    checkOutput("oor_err", 32'(s_err), 32'h1);
    tick();
    checkOutput("oor_err_sticky", 32'(s_err), 32'h1);
    checkOutput("oor_ready_next", 32'(s_ready), 32'h1);
`else
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("oor_o_c%0d", c), 32'(s_o), 32'h0);
      checkOutput($sformatf("oor_busy_c%0d", c), 32'(s_busy), 32'h1);
      checkOutput($sformatf("oor_err_c%0d", c), 32'(s_err), 32'h0);
      tick();
    end
    checkOutput("oor_gap_busy", 32'(s_busy), 32'h1);
    tick();
    checkOutput("oor_ready_after", 32'(s_ready), 32'h1);
`endif
    s_valid = 1'b1; s_i = 2'd2;
    tick();
    s_valid = 1'b0;
    checkOutput("small_o_top", 32'(s_o), 32'h4);
`ifdef DECODER_STROBE_ERR_EN
    checkOutput("small_err_held", 32'(s_err), 32'h1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    checkOutput("small_err_cleared", 32'(s_err), 32'h0);
`else
    checkOutput("small_err_zero", 32'(s_err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
